// File: rtl/rv_regfile_pkg.sv
// Shared definitions for the register-file clients: widths, instruction
// field positions and small field-extraction helpers.
package rv_regfile_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int ILEN    = 32;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;
    localparam int NUM_SRC = 2;

    typedef logic [REG_AW-1:0] reg_idx_t;

    function automatic reg_idx_t rs1_of(input logic [ILEN-1:0] instr);
        return instr[RS1_LSB +: REG_AW];
    endfunction

    function automatic reg_idx_t rs2_of(input logic [ILEN-1:0] instr);
        return instr[RS2_LSB +: REG_AW];
    endfunction

    function automatic reg_idx_t rd_of(input logic [ILEN-1:0] instr);
        return instr[RD_LSB +: REG_AW];
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Operand selector for one source register: x0 reads as zero, a same-cycle
// writeback to the same register wins over the register-file data.
module operand_bypass
    import rv_regfile_pkg::*;
(
    input  logic [REG_AW-1:0] idx,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_idx,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   operand
);

    logic wb_hit;

    assign wb_hit = wb_we && (wb_idx == idx) && (idx != '0);

    // Zero for x0, otherwise forwarded writeback data or register-file data
    always_comb begin
        operand = rf_data;
        if (idx == '0) begin
            operand = '0;
        end else if (wb_hit) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads both source registers (with writeback forwarding) and
// holds instruction plus operands in a single valid/ready slot for execute.
// While the slot is stalled, writebacks to its source registers refresh the
// held operands so execute never sees a stale value.
module operand_fetch_stage
    import rv_regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_instr,
    output logic [REG_AW-1:0] ReadRegister1,
    output logic [REG_AW-1:0] ReadRegister2,
    input  logic [XLEN-1:0]   ReadData1,
    input  logic [XLEN-1:0]   ReadData2,
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_WriteRegister,
    input  logic [XLEN-1:0]   wb_WriteData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ILEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [31:0]       stall_count
);

    logic            out_valid_reg;
    logic [ILEN-1:0] instr_reg;
    logic [XLEN-1:0] operand_reg     [NUM_SRC];
    logic [31:0]     stall_count_reg;
    logic [31:0]     stall_count_next;

    reg_idx_t        fetch_idx       [NUM_SRC];
    reg_idx_t        held_idx        [NUM_SRC];
    logic [XLEN-1:0] rf_data         [NUM_SRC];
    logic [XLEN-1:0] fetch_operand   [NUM_SRC];
    logic [XLEN-1:0] refresh_operand [NUM_SRC];

    logic accept;
    logic consume;
    logic stalled;

    assign fetch_idx[0] = rs1_of(in_instr);
    assign fetch_idx[1] = rs2_of(in_instr);
    assign held_idx[0]  = rs1_of(instr_reg);
    assign held_idx[1]  = rs2_of(instr_reg);
    assign rf_data[0]   = ReadData1;
    assign rf_data[1]   = ReadData2;

    // One bypass on the fetch path and one refreshing the held operand, per source
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            operand_bypass u_fetch_bypass (
                .idx     (fetch_idx[gi]),
                .rf_data (rf_data[gi]),
                .wb_we   (wb_RegWrite),
                .wb_idx  (wb_WriteRegister),
                .wb_data (wb_WriteData),
                .operand (fetch_operand[gi])
            );

            operand_bypass u_held_bypass (
                .idx     (held_idx[gi]),
                .rf_data (operand_reg[gi]),
                .wb_we   (wb_RegWrite),
                .wb_idx  (wb_WriteRegister),
                .wb_data (wb_WriteData),
                .operand (refresh_operand[gi])
            );
        end
    endgenerate

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_reg && out_ready;
    assign stalled  = out_valid_reg && !out_ready && !flush;

    // Saturating count of cycles the slot is held back by execute
    always_comb begin
        stall_count_next = stall_count_reg;
        if (stalled && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_next = stall_count_reg + 32'd1;
        end
    end

    // Slot update: flush beats accept, accept beats consume, otherwise hold and refresh
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_reg   <= 1'b0;
            instr_reg       <= '0;
            stall_count_reg <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                operand_reg[i] <= '0;
            end
        end else begin
            stall_count_reg <= stall_count_next;
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (accept) begin
                out_valid_reg <= 1'b1;
                instr_reg     <= in_instr;
                for (int i = 0; i < NUM_SRC; i++) begin
                    operand_reg[i] <= fetch_operand[i];
                end
            end else if (consume) begin
                out_valid_reg <= 1'b0;
            end else if (out_valid_reg) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    operand_reg[i] <= refresh_operand[i];
                end
            end
        end
    end

    assign ReadRegister1 = fetch_idx[0];
    assign ReadRegister2 = fetch_idx[1];
    assign out_valid     = out_valid_reg;
    assign out_instr     = instr_reg;
    assign out_rs1_data  = operand_reg[0];
    assign out_rs2_data  = operand_reg[1];
    assign stall_count   = stall_count_reg;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage with a behavioural 32x32 register file whose
// write port is shared with the stage's writeback inputs.
module tb_operand_fetch_stage;

    logic        CLK;
    logic        RESET_N;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        wb_RegWrite;
    logic [4:0]  wb_WriteRegister;
    logic [31:0] wb_WriteData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [31:0] stall_count;

    int total_checks;
    int passed_checks;

    logic [31:0] rf [32];

    operand_fetch_stage dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .ReadRegister1    (ReadRegister1),
        .ReadRegister2    (ReadRegister2),
        .ReadData1        (ReadData1),
        .ReadData2        (ReadData2),
        .wb_RegWrite      (wb_RegWrite),
        .wb_WriteRegister (wb_WriteRegister),
        .wb_WriteData     (wb_WriteData),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_rs1_data     (out_rs1_data),
        .out_rs2_data     (out_rs2_data),
        .stall_count      (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: async read, write at the edge, x0 never written
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (wb_RegWrite && (wb_WriteRegister != 5'd0)) begin
            rf[wb_WriteRegister] <= wb_WriteData;
        end
    end

    always_comb begin
        ReadData1 = rf[ReadRegister1];
        ReadData2 = rf[ReadRegister2];
    end

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] mk(input int tag, input logic [4:0] rs1, input logic [4:0] rs2);
        logic [6:0] t;
        t = 7'(tag);
        return {t, rs2, rs1, 3'b000, 5'd0, 7'h33};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rf_write(input logic [4:0] r, input logic [31:0] d);
        wb_RegWrite      = 1'b1;
        wb_WriteRegister = r;
        wb_WriteData     = d;
        tick();
        wb_RegWrite      = 1'b0;
    endtask

    logic [31:0] h_instr;
    logic [31:0] t_instr;
    logic [31:0] y_instr;

    initial begin
        total_checks     = 0;
        passed_checks    = 0;
        RESET_N          = 1'b0;
        flush            = 1'b0;
        in_valid         = 1'b0;
        in_instr         = 32'h0;
        out_ready        = 1'b0;
        wb_RegWrite      = 1'b0;
        wb_WriteRegister = 5'd0;
        wb_WriteData     = 32'h0;

        //            rs1    rs2    we    wr     wd            exp1          exp2
        vecs[0] = '{5'd1, 5'd2, 1'b0, 5'd0, 32'h00000000, 32'h11111111, 32'h22222222};
        vecs[1] = '{5'd0, 5'd1, 1'b1, 5'd0, 32'h12345678, 32'h00000000, 32'h11111111};
        vecs[2] = '{5'd3, 5'd3, 1'b1, 5'd3, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA};
        vecs[3] = '{5'd3, 5'd1, 1'b0, 5'd0, 32'h00000000, 32'hAAAAAAAA, 32'h11111111};
        vecs[4] = '{5'd2, 5'd5, 1'b1, 5'd5, 32'h0000BEEF, 32'h22222222, 32'h0000BEEF};
        vecs[5] = '{5'd4, 5'd0, 1'b1, 5'd4, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
        vecs[6] = '{5'd1, 5'd4, 1'b1, 5'd1, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'hDEADBEEF};
        vecs[7] = '{5'd6, 5'd7, 1'b1, 5'd2, 32'hCAFEF00D, 32'h00000000, 32'h00000000};

        // Reset state
        #10;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_rs1", out_rs1_data, 32'h0);
        chk("reset_rs2", out_rs2_data, 32'h0);
        chk("reset_stall", stall_count, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        #10;
        RESET_N = 1'b1;
        tick();

        rf_write(5'd1, 32'h11111111);
        rf_write(5'd2, 32'h22222222);
        rf_write(5'd3, 32'h33333333);

        // Table: back-to-back issue with forwarding cases
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid         = 1'b1;
            in_instr         = mk(i + 1, vecs[i].rs1, vecs[i].rs2);
            wb_RegWrite      = vecs[i].we;
            wb_WriteRegister = vecs[i].wr;
            wb_WriteData     = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_rdreg1", i), 32'(ReadRegister1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rdreg2", i), 32'(ReadRegister2), 32'(vecs[i].rs2));
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_instr", i), out_instr, mk(i + 1, vecs[i].rs1, vecs[i].rs2));
            chk($sformatf("v%0d_rs1", i), out_rs1_data, vecs[i].exp1);
            chk($sformatf("v%0d_rs2", i), out_rs2_data, vecs[i].exp2);
            $display("vec %0d rs1=%0d rs2=%0d -> %h %h", i, vecs[i].rs1, vecs[i].rs2,
                     out_rs1_data, out_rs2_data);
        end
        wb_RegWrite = 1'b0;

        // Hold: load H (rs1=1, rs2=2), then stall with refreshing writebacks
        h_instr  = mk(20, 5'd1, 5'd2);
        in_instr = h_instr;
        tick();
        chk("h_load_rs1", out_rs1_data, 32'h0F0F0F0F);
        chk("h_load_rs2", out_rs2_data, 32'hCAFEF00D);
        chk("h_load_stall", stall_count, 32'd0);
        out_ready = 1'b0;
        in_instr  = mk(21, 5'd3, 5'd3);
        wb_RegWrite = 1'b1; wb_WriteRegister = 5'd2; wb_WriteData = 32'h5555AAAA;
        #1;
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("hold1_rs2", out_rs2_data, 32'h5555AAAA);
        chk("hold1_rs1", out_rs1_data, 32'h0F0F0F0F);
        chk("hold1_instr", out_instr, h_instr);
        chk("hold1_stall", stall_count, 32'd1);
        wb_WriteRegister = 5'd1; wb_WriteData = 32'h12121212;
        tick();
        chk("hold2_rs1", out_rs1_data, 32'h12121212);
        chk("hold2_stall", stall_count, 32'd2);
        wb_WriteRegister = 5'd9; wb_WriteData = 32'h99999999;
        tick();
        chk("hold3_rs1", out_rs1_data, 32'h12121212);
        chk("hold3_rs2", out_rs2_data, 32'h5555AAAA);
        chk("hold3_stall", stall_count, 32'd3);
        $display("hold done stall_count=%0d", stall_count);
        wb_RegWrite = 1'b0;

        // Four back-to-back transfers
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t_instr  = mk(30 + k, 5'(k + 1), 5'(k + 2));
            in_instr = t_instr;
            in_valid = 1'b1;
            #1;
            chk($sformatf("b2b%0d_in_ready", k), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("b2b%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d_instr", k), out_instr, t_instr);
            $display("b2b %0d instr=%h", k, out_instr);
        end
        chk("b2b_stall", stall_count, 32'd3);

        // Flush drops the held and the incoming instruction; no stall counted
        out_ready = 1'b0;
        flush     = 1'b1;
        in_instr  = mk(40, 5'd1, 5'd1);
        tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_stall", stall_count, 32'd3);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_flush_valid", 32'(out_valid), 32'd0);

        // Consume without accept: valid drops, data holds
        y_instr  = mk(41, 5'd3, 5'd4);
        in_instr = y_instr;
        in_valid = 1'b1;
        tick();
        chk("y_valid", 32'(out_valid), 32'd1);
        chk("y_rs1", out_rs1_data, 32'hAAAAAAAA);
        chk("y_rs2", out_rs2_data, 32'hDEADBEEF);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("consume_valid", 32'(out_valid), 32'd0);
        chk("consume_instr", out_instr, y_instr);
        chk("consume_stall", stall_count, 32'd3);

        // Async reset during a hold
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(42, 5'd5, 5'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_stall", stall_count, 32'd5);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_stall", stall_count, 32'd0);
        chk("async_reset_instr", out_instr, 32'h0);
        chk("async_reset_in_ready", 32'(in_ready), 32'd1);
        #2;
        RESET_N = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
